// File: rtl/capture_readout_fifo.sv
// Capture result FIFO: buffers timer captures behind a first-word-fall-through read port.
// Optional CAPTURE_DELTA_EN stores differences between consecutive accepted captures instead of raw counts.
module capture_readout_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_an_i,
    input  logic [DATA_W-1:0] captured_i,
    input  logic              capture_valid_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [AW:0]       level_o,
    output logic              overflow_o,
    input  logic              overflow_clr_i,
    output logic [DROP_W-1:0] drop_cnt_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              empty, full, pop_req, push, pop, drop;
    logic [DATA_W-1:0] wr_data;

`ifdef CAPTURE_DELTA_EN
    logic [DATA_W-1:0] last_q, last_d;

    // Modular difference: wraps rather than saturating.
    assign wr_data = captured_i - last_q;

    always_comb begin
        last_d = last_q;
        if (flush_i) begin
            last_d = '0;
        end else if (push) begin
            last_d = captured_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_an_i) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign wr_data = captured_i;
`endif

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop_req = ~empty & rd_ready_i;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts a capture.
        push    = capture_valid_i & (~full | pop_req) & ~flush_i;
        pop     = pop_req & ~flush_i;
        drop    = capture_valid_i & full & ~pop_req & ~flush_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clr_i) begin
                drop_cnt_d = DROP_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_an_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; stale entries are hidden because the read port is gated by empty.
    always_ff @(posedge clk_i) begin
        if (rst_an_i && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_valid_o = ~empty;
    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_capture_readout_fifo.sv
// Directed bench for capture_readout_fifo: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios (delta scenario under CAPTURE_DELTA_EN).
module tb_capture_readout_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;
    localparam int AW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_an = 1'b0;
    logic [DATA_W-1:0] captured = '0;
    logic              cap_valid = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [AW:0]       level;
    logic              overflow;
    logic              ovf_clr = 1'b0;
    logic [DROP_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] got[$];
    logic              m_ovf = 1'b0;
    logic [DROP_W-1:0] m_cnt = '0;
    logic [DATA_W-1:0] m_last = '0;
    bit                m_pop, m_drop, m_full;

    always #5 clk = ~clk;

    capture_readout_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk_i           (clk),
        .rst_an_i        (rst_an),
        .captured_i      (captured),
        .capture_valid_i (cap_valid),
        .flush_i         (flush),
        .rd_data_o       (rd_data),
        .rd_valid_o      (rd_valid),
        .rd_ready_i      (rd_ready),
        .level_o         (level),
        .overflow_o      (overflow),
        .overflow_clr_i  (ovf_clr),
        .drop_cnt_o      (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, updated from the inputs seen at each rising edge.
    always @(posedge clk) begin
        if (!rst_an) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_cnt  = '0;
            m_last = '0;
        end else begin
            m_pop  = (mq.size() != 0) && rd_ready;
            m_drop = 1'b0;
            m_full = (mq.size() == DEPTH);
            if (flush) begin
                mq.delete();
                m_last = '0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (cap_valid) begin
                    if (!m_full || m_pop) begin
`ifdef CAPTURE_DELTA_EN
                        mq.push_back(captured - m_last);
`else
                        mq.push_back(captured);
`endif
                        m_last = captured;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
            end
            if (m_drop) begin
                m_ovf = 1'b1;
                if (ovf_clr) m_cnt = 1;
                else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
                m_cnt = '0;
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", rd_valid, mq.size() != 0);
            chk("rd_data", rd_data, (mq.size() != 0) ? mq[0] : 32'h0);
            chk("level", level, mq.size());
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_cnt);
            if (rd_valid && rd_ready) begin
                got.push_back(rd_data);
                $display("read   data=%h level=%0d", rd_data, level);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        cap_valid = 1'b1;
        captured  = v;
        tick();
        cap_valid = 1'b0;
        $display("push   data=%h level=%0d", v, level);
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        tick(n);
        rd_ready = 1'b0;
    endtask

    initial begin
        // Reset
        tick(2);
        chk("reset_valid", rd_valid, 0);
        chk("reset_data", rd_data, 0);
        chk("reset_level", level, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_cnt", drop_cnt, 0);
        rst_an = 1'b1;
        chk_en = 1'b1;

        // Three pushes, no reader, then drain
        push(32'h10);
        chk("valid_after_first_push", rd_valid, 1);
        push(32'h25);
        push(32'h40);
        chk("level_3", level, 3);
        chk("head_0x10", rd_data, 32'h10);
        got.delete();
        drain(3);
        chk("empty_after_drain", rd_valid, 0);
        chk("level_0", level, 0);
        chk("reads_count", got.size(), 3);
`ifndef CAPTURE_DELTA_EN
        if (got.size() == 3) begin
            chk("read0", got[0], 32'h10);
            chk("read1", got[1], 32'h25);
            chk("read2", got[2], 32'h40);
        end
`endif

        // Fill, then two drops
        for (int i = 1; i <= 8; i++) push(i);
        push(32'h9);
        push(32'hA);
        chk("full_level", level, 8);
        chk("ovf_set", overflow, 1);
        chk("drop_2", drop_cnt, 2);
        got.delete();
        drain(8);
        chk("full_reads", got.size(), 8);
`ifndef CAPTURE_DELTA_EN
        for (int i = 0; i < 8 && i < got.size(); i++) chk("full_read_val", got[i], i + 1);
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        chk("cnt_cleared", drop_cnt, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(32'h11 + i);
        cap_valid = 1'b1;
        captured  = 32'h99;
        rd_ready  = 1'b1;
        tick();
        cap_valid = 1'b0;
        rd_ready  = 1'b0;
        chk("full_pushpop_level", level, 8);
        chk("full_pushpop_ovf", overflow, 0);
        got.delete();
        drain(8);
`ifndef CAPTURE_DELTA_EN
        if (got.size() == 8) chk("last_read_0x99", got[7], 32'h99);
`endif

        // Clear in the same cycle as a drop: set wins
        for (int i = 0; i < 8; i++) push(32'h41 + i);
        push(32'hE1);
        cap_valid = 1'b1;
        captured  = 32'hE2;
        ovf_clr   = 1'b1;
        tick();
        cap_valid = 1'b0;
        ovf_clr   = 1'b0;
        chk("clr_drop_ovf", overflow, 1);
        chk("clr_drop_cnt", drop_cnt, 1);

        // Down to 3 entries, then flush with a concurrent push
        drain(5);
        chk("level_before_flush", level, 3);
        flush     = 1'b1;
        cap_valid = 1'b1;
        captured  = 32'h77;
        tick();
        flush     = 1'b0;
        cap_valid = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_valid", rd_valid, 0);
        chk("flush_ovf_kept", overflow, 1);
        chk("flush_cnt_kept", drop_cnt, 1);
        push(32'h55);
        got.delete();
        drain(2);
        chk("post_flush_reads", got.size(), 1);
        if (got.size() == 1) chk("no_0x77", got[0], 32'h55);

        // Drop counter saturation
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        cap_valid = 1'b1;
        captured  = 32'hDEAD;
        tick(65540);
        cap_valid = 1'b0;
        chk("sat_cnt", drop_cnt, 16'hFFFF);
        chk("sat_ovf", overflow, 1);
        chk("sat_level", level, 8);
        flush = 1'b1;
        tick();
        flush = 1'b0;

`ifdef CAPTURE_DELTA_EN
        push(32'd100);
        push(32'd250);
        push(32'h5);
        got.delete();
        drain(3);
        chk("delta_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("delta0", got[0], 32'd100);
            chk("delta1", got[1], 32'd150);
            chk("delta2", got[2], 32'hFFFFFF0B);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push(32'd30);
        got.delete();
        drain(1);
        if (got.size() == 1) chk("delta_after_flush", got[0], 32'd30);
        else chk("delta_after_flush_count", got.size(), 1);
`endif

        // Reset mid-operation
        push(32'h123);
        push(32'h456);
        rst_an = 1'b0;
        tick();
        chk("midrst_level", level, 0);
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_data", rd_data, 0);
        chk("midrst_cnt", drop_cnt, 0);
        rst_an = 1'b1;
        tick(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
